// File: rtl/bp_pkg.sv
// Shared definitions for the branch-history table write-port controller.
package bp_pkg;

  localparam int unsigned BP_IDX_W  = 10;
  localparam int unsigned BP_PC_LSB = 2;

  // Queued branch resolution at the default table size.
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                taken;
  } bp_entry_t;

  typedef enum logic {SWEEP, RUN} bp_state_t;

  // Extracts the table index bits PC[lsb+w-1:lsb]; callers size-cast to w bits.
  function automatic logic [31:0] pc2idx(input logic [31:0] pc,
                                         input int unsigned lsb,
                                         input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (pc >> lsb) & mask;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: synchronous FIFO with a parallel view of all valid entry indices.
module bp_upd_fifo #(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        push,
  input  logic [IDX_W-1:0]            push_idx,
  input  logic                        push_taken,
  input  logic                        pop,
  input  logic                        flush,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [IDX_W-1:0]            head_idx,
  output logic                        head_taken,
  output logic [DEPTH-1:0]            entry_vld,
  output logic [DEPTH-1:0][IDX_W-1:0] entry_idx
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (count == (AW+1)'(DEPTH));
  assign head_idx   = mem[rd_ptr[AW-1:0]].idx;
  assign head_taken = mem[rd_ptr[AW-1:0]].taken;

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while the slot is valid.
  always_ff @(posedge CLK) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= '{idx: push_idx, taken: push_taken};
  end

  // A slot is valid when its distance from the read pointer is below the count.
  always_comb begin
    entry_vld = '0;
    entry_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_idx[i] = mem[i].idx;
      entry_vld[i] = {1'b0, AW'(AW'(i) - rd_ptr[AW-1:0])} < count;
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Write-port controller for the local branch-history table: post-reset/flush
// zero sweep, queued update drain, and stale-lookup hazard flag.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = BP_IDX_W,
  parameter int unsigned PC_LSB     = BP_PC_LSB,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [31:0]                       ID_PC,
  input  logic                              Is_Branch,
  input  logic                              Is_Taken,
  input  logic                              Flush_Req,
  input  logic [31:0]                       IF_PC,
  output logic                              Tbl_WE,
  output logic [IDX_W-1:0]                  Tbl_Index,
  output logic                              Tbl_Clear,
  output logic                              Tbl_Taken,
  output logic                              Stall,
  output logic                              Busy,
  output logic                              Lookup_Hazard,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   Pending_Count
);

  bp_state_t                     state;
  logic [IDX_W-1:0]              sweep_ptr;
  logic [IDX_W-1:0]              id_idx;
  logic [IDX_W-1:0]              if_idx;
  logic                          q_push;
  logic                          q_pop;
  logic                          q_full;
  logic                          q_empty;
  logic [IDX_W-1:0]              q_head_idx;
  logic                          q_head_taken;
  logic [FIFO_DEPTH-1:0]         q_vld;
  logic [FIFO_DEPTH-1:0][IDX_W-1:0] q_idx;

  assign id_idx = IDX_W'(pc2idx(ID_PC, PC_LSB, IDX_W));
  assign if_idx = IDX_W'(pc2idx(IF_PC, PC_LSB, IDX_W));

  // Stall ignores a same-cycle pop so it depends only on registered pointers.
  assign Stall  = q_full;
  assign q_push = Is_Branch && !q_full && !Flush_Req;
  assign q_pop  = (state == RUN) && !q_empty && !Flush_Req;

  bp_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (q_push),
    .push_idx   (id_idx),
    .push_taken (Is_Taken),
    .pop        (q_pop),
    .flush      (Flush_Req),
    .full       (q_full),
    .empty      (q_empty),
    .count      (Pending_Count),
    .head_idx   (q_head_idx),
    .head_taken (q_head_taken),
    .entry_vld  (q_vld),
    .entry_idx  (q_idx)
  );

  // Controller FSM: sweep every index once, then drain the queue one entry per cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
      Tbl_WE    <= 1'b0;
      Tbl_Index <= '0;
      Tbl_Clear <= 1'b0;
      Tbl_Taken <= 1'b0;
      Busy      <= 1'b1;
    end else if (Flush_Req) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
      Tbl_WE    <= 1'b0;
      Tbl_Index <= '0;
      Tbl_Clear <= 1'b0;
      Tbl_Taken <= 1'b0;
      Busy      <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          Tbl_WE    <= 1'b1;
          Tbl_Clear <= 1'b1;
          Tbl_Index <= sweep_ptr;
          Tbl_Taken <= 1'b0;
          sweep_ptr <= sweep_ptr + 1'b1;
          Busy      <= 1'b1;
          if (&sweep_ptr) state <= RUN;
        end
        RUN: begin
          // Busy stays high through the last sweep write and drops here.
          Busy      <= 1'b0;
          Tbl_Clear <= 1'b0;
          Tbl_WE    <= q_pop;
          if (q_pop) begin
            Tbl_Index <= q_head_idx;
            Tbl_Taken <= q_head_taken;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  // Hazard when sweeping, or the fetch index matches a queued or in-flight update.
  always_comb begin
    Lookup_Hazard = Busy;
    if (Tbl_WE && (Tbl_Index == if_idx)) Lookup_Hazard = 1'b1;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i] && (q_idx[i] == if_idx)) Lookup_Hazard = 1'b1;
    end
  end

endmodule
